// File: rtl/cgra_isa_pkg.sv
// ============================================================================
// Module      : cgra_isa_pkg
// Description : Shared CGRA instruction-set definitions for fragment
//               sequencing: opcodes, field positions, error codes, states
//               and the dispatch bundle layout.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cgra_isa_pkg;

  // Opcode field [31:29]; 010 and 111 are reserved.
  localparam logic [2:0] OP_D0  = 3'b000;
  localparam logic [2:0] OP_D1  = 3'b001;
  localparam logic [2:0] OP_T   = 3'b011;
  localparam logic [2:0] OP_I   = 3'b100;
  localparam logic [2:0] OP_W   = 3'b101;
  localparam logic [2:0] OP_HDR = 3'b110;

  // Field positions shared by D/W words and the header.
  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 29;
  localparam int FUNCT_MSB   = 28;
  localparam int FUNCT_LSB   = 25;
  localparam int IMMAB_BIT   = 24;
  localparam int IMMLO_MSB   = 23;
  localparam int IMMLO_LSB   = 18;
  localparam int HDR_END_BIT = 28;
  localparam int IMMHI_W     = 26;
  localparam int IMMLO_W     = 6;

  // Error codes, lowest to highest priority.
  localparam logic [1:0] ERR_RSV     = 2'd0;
  localparam logic [1:0] ERR_OUTSIDE = 2'd1;
  localparam logic [1:0] ERR_DUP     = 2'd2;
  localparam logic [1:0] ERR_LOST    = 2'd3;

  typedef enum logic [0:0] {
    S_HDR  = 1'b0,
    S_BODY = 1'b1
  } seq_state_e;

  // Fully assembled instruction handed to dispatch.
  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  funct;
    logic        immab;
    logic [31:0] imm;
    logic [9:0]  offset;
    logic [23:0] ta;      // {ta4, ta3, ta2, ta1}
    logic [7:0]  tt;      // {tt4, tt3, tt2, tt1}
    logic        has_t;
    logic        has_i;
  } bundle_t;

endpackage

`default_nettype wire

// File: rtl/prefix_buffer.sv
// ============================================================================
// Module      : prefix_buffer
// Description : Holds the pending T and I prefix fields until the next D/W
//               word consumes them. Clear wins over load so a prefix that
//               dangles at the end of a fragment is dropped.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prefix_buffer
  import cgra_isa_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IMMHI_W-1:0] word,
  input  logic               t_load,
  input  logic               i_load,
  input  logic               clear,
  output logic               t_pend,
  output logic               i_pend,
  output logic [11:0]        t_ta,    // {ta4, ta3}
  output logic [3:0]         t_tt,    // {tt4, tt3}
  output logic [IMMHI_W-1:0] immhi,
  output logic               dup
);

  logic               t_pend_q, t_pend_d;
  logic               i_pend_q, i_pend_d;
  logic [11:0]        t_ta_q, t_ta_d;
  logic [3:0]         t_tt_q, t_tt_d;
  logic [IMMHI_W-1:0] immhi_q, immhi_d;

  // Next prefix contents: a new prefix overwrites, clear drops everything.
  always_comb begin
    t_pend_d = t_pend_q;
    i_pend_d = i_pend_q;
    t_ta_d   = t_ta_q;
    t_tt_d   = t_tt_q;
    immhi_d  = immhi_q;
    if (t_load) begin
      t_pend_d = 1'b1;
      t_ta_d   = {word[13:8], word[5:0]};
      t_tt_d   = {word[15:14], word[7:6]};
    end
    if (i_load) begin
      i_pend_d = 1'b1;
      immhi_d  = word;
    end
    if (clear) begin
      t_pend_d = 1'b0;
      i_pend_d = 1'b0;
      t_ta_d   = '0;
      t_tt_d   = '0;
      immhi_d  = '0;
    end
  end

  // Prefix registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_pend_q <= 1'b0;
      i_pend_q <= 1'b0;
      t_ta_q   <= '0;
      t_tt_q   <= '0;
      immhi_q  <= '0;
    end else begin
      t_pend_q <= t_pend_d;
      i_pend_q <= i_pend_d;
      t_ta_q   <= t_ta_d;
      t_tt_q   <= t_tt_d;
      immhi_q  <= immhi_d;
    end
  end

  assign t_pend = t_pend_q;
  assign i_pend = i_pend_q;
  assign t_ta   = t_ta_q;
  assign t_tt   = t_tt_q;
  assign immhi  = immhi_q;
  assign dup    = (t_load && t_pend_q) || (i_load && i_pend_q);

endmodule

`default_nettype wire

// File: rtl/fragment_sequencer.sv
// ============================================================================
// Module      : fragment_sequencer
// Description : Parses CGRA fragment headers, counts body words, merges T/I
//               prefixes into D/W words and emits one registered bundle per
//               D/W word over valid/ready. Protocol errors pulse err.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fragment_sequencer
  import cgra_isa_pkg::*;
#(
  parameter int NALLOC_W = 7,
  parameter int SEXT_IMM = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [31:0]         in_word,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_op,
  output logic [3:0]          out_funct,
  output logic                out_immab,
  output logic [31:0]         out_imm,
  output logic [9:0]          out_offset,
  output logic [23:0]         out_ta,
  output logic [7:0]          out_tt,
  output logic                out_has_t,
  output logic                out_has_i,
  output logic [NALLOC_W-1:0] out_slot,
  output logic                frag_done,
  output logic                prog_done,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [NALLOC_W-1:0] C_ONE = {{(NALLOC_W-1){1'b0}}, 1'b1};

  seq_state_e          state_q, state_d;
  logic                end_q, end_d;
  logic [NALLOC_W-1:0] remaining_q, remaining_d;
  logic [NALLOC_W-1:0] slot_q, slot_d;
  bundle_t             bundle_q, bundle_d;
  logic                out_valid_q, out_valid_d;
  logic [NALLOC_W-1:0] out_slot_q, out_slot_d;
  logic                frag_done_q, frag_done_d;
  logic                prog_done_q, prog_done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                accept;
  logic [2:0]          op;
  logic                is_hdr, is_d, is_w, is_t, is_i, is_rsv;
  logic [NALLOC_W-1:0] nalloc;
  logic [IMMLO_W-1:0]  immlo;
  bundle_t             bundle_new;

  logic                pb_t_load, pb_i_load, pb_clear;
  logic                pb_t_pend, pb_i_pend, pb_dup;
  logic [11:0]         pb_t_ta;
  logic [3:0]          pb_t_tt;
  logic [IMMHI_W-1:0]  pb_immhi;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign op       = in_word[OP_MSB:OP_LSB];
  assign nalloc   = in_word[NALLOC_W-1:0];
  assign immlo    = in_word[IMMLO_MSB:IMMLO_LSB];

  // Opcode decode.
  always_comb begin
    is_hdr = 1'b0;
    is_d   = 1'b0;
    is_w   = 1'b0;
    is_t   = 1'b0;
    is_i   = 1'b0;
    is_rsv = 1'b0;
    case (op)
      OP_D0, OP_D1: is_d   = 1'b1;
      OP_W:         is_w   = 1'b1;
      OP_T:         is_t   = 1'b1;
      OP_I:         is_i   = 1'b1;
      OP_HDR:       is_hdr = 1'b1;
      default:      is_rsv = 1'b1;
    endcase
  end

  // Prefixes are only captured inside a fragment; kept outside the main
  // next-state block so the duplicate flag has no path back through it.
  assign pb_t_load = accept && (state_q == S_BODY) && is_t;
  assign pb_i_load = accept && (state_q == S_BODY) && is_i;

  prefix_buffer u_prefix_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .word   (in_word[IMMHI_W-1:0]),
    .t_load (pb_t_load),
    .i_load (pb_i_load),
    .clear  (pb_clear),
    .t_pend (pb_t_pend),
    .i_pend (pb_i_pend),
    .t_ta   (pb_t_ta),
    .t_tt   (pb_t_tt),
    .immhi  (pb_immhi),
    .dup    (pb_dup)
  );

  // Assemble a bundle from the current D/W word and pending prefixes.
  always_comb begin
    bundle_new        = '0;
    bundle_new.op     = op;
    bundle_new.funct  = in_word[FUNCT_MSB:FUNCT_LSB];
    bundle_new.immab  = in_word[IMMAB_BIT];
    bundle_new.has_t  = pb_t_pend;
    bundle_new.has_i  = pb_i_pend;
    bundle_new.offset = is_w ? in_word[9:0] : 10'd0;
    bundle_new.ta     = {pb_t_ta, (is_d ? {in_word[13:8], in_word[5:0]} : 12'd0)};
    bundle_new.tt     = {pb_t_tt, (is_d ? {in_word[15:14], in_word[7:6]} : 4'd0)};
    if (pb_i_pend) begin
      bundle_new.imm = {pb_immhi, immlo};
    end else if (SEXT_IMM != 0) begin
      bundle_new.imm = {{(32-IMMLO_W){immlo[IMMLO_W-1]}}, immlo};
    end else begin
      bundle_new.imm = {{(32-IMMLO_W){1'b0}}, immlo};
    end
  end

  // Sequencer next state: header parsing, body counting, bundle load and
  // error reporting. Later error assignments override earlier ones, which
  // gives the 3 > 2 > 1 > 0 priority.
  always_comb begin
    state_d     = state_q;
    end_d       = end_q;
    remaining_d = remaining_q;
    slot_d      = slot_q;
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q && !out_ready;
    out_slot_d  = out_slot_q;
    frag_done_d = 1'b0;
    prog_done_d = prog_done_q;
    err_d       = 1'b0;
    err_code_d  = ERR_RSV;
    pb_clear    = 1'b0;

    if (accept) begin
      if (is_hdr) begin
        if (state_q == S_BODY) begin
          // Header inside a fragment aborts it silently apart from the error.
          err_d      = 1'b1;
          err_code_d = ERR_LOST;
          pb_clear   = 1'b1;
        end
        end_d       = in_word[HDR_END_BIT];
        remaining_d = nalloc;
        slot_d      = '0;
        prog_done_d = 1'b0;
        if (nalloc == '0) begin
          frag_done_d = 1'b1;
          prog_done_d = in_word[HDR_END_BIT];
          state_d     = S_HDR;
        end else begin
          state_d = S_BODY;
        end
      end else if (state_q == S_HDR) begin
        err_d      = 1'b1;
        err_code_d = ERR_OUTSIDE;
      end else begin
        remaining_d = remaining_q - C_ONE;
        slot_d      = slot_q + C_ONE;
        if (is_d || is_w) begin
          bundle_d    = bundle_new;
          out_valid_d = 1'b1;
          out_slot_d  = slot_q;
          pb_clear    = 1'b1;
        end
        if (is_rsv) begin
          err_d      = 1'b1;
          err_code_d = ERR_RSV;
        end
        if (pb_dup) begin
          err_d      = 1'b1;
          err_code_d = ERR_DUP;
        end
        if (remaining_q == C_ONE) begin
          frag_done_d = 1'b1;
          state_d     = S_HDR;
          if (end_q) begin
            prog_done_d = 1'b1;
          end
          // A prefix left over at the end of the fragment has no consumer.
          if (!(is_d || is_w) && (pb_t_pend || pb_i_pend || is_t || is_i)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LOST;
            pb_clear   = 1'b1;
          end
        end
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      end_q       <= 1'b0;
      remaining_q <= '0;
      slot_q      <= '0;
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      out_slot_q  <= '0;
      frag_done_q <= 1'b0;
      prog_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_RSV;
    end else begin
      state_q     <= state_d;
      end_q       <= end_d;
      remaining_q <= remaining_d;
      slot_q      <= slot_d;
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      out_slot_q  <= out_slot_d;
      frag_done_q <= frag_done_d;
      prog_done_q <= prog_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = bundle_q.op;
  assign out_funct  = bundle_q.funct;
  assign out_immab  = bundle_q.immab;
  assign out_imm    = bundle_q.imm;
  assign out_offset = bundle_q.offset;
  assign out_ta     = bundle_q.ta;
  assign out_tt     = bundle_q.tt;
  assign out_has_t  = bundle_q.has_t;
  assign out_has_i  = bundle_q.has_i;
  assign out_slot   = out_slot_q;
  assign frag_done  = frag_done_q;
  assign prog_done  = prog_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_fragment_sequencer.sv
// ============================================================================
// Module      : tb_fragment_sequencer
// Description : Directed self-checking bench for fragment_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fragment_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [3:0]  out_funct;
  logic        out_immab;
  logic [31:0] out_imm;
  logic [9:0]  out_offset;
  logic [23:0] out_ta;
  logic [7:0]  out_tt;
  logic        out_has_t;
  logic        out_has_i;
  logic [6:0]  out_slot;
  logic        frag_done;
  logic        prog_done;
  logic        err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fragment_sequencer #(.NALLOC_W(7), .SEXT_IMM(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_funct  (out_funct),
    .out_immab  (out_immab),
    .out_imm    (out_imm),
    .out_offset (out_offset),
    .out_ta     (out_ta),
    .out_tt     (out_tt),
    .out_has_t  (out_has_t),
    .out_has_i  (out_has_i),
    .out_slot   (out_slot),
    .frag_done  (frag_done),
    .prog_done  (prog_done),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_hdr(input logic e, input logic [6:0] n);
    return {3'b110, e, 21'd0, n};
  endfunction

  function automatic logic [31:0] f_t(input logic [1:0] tt4, input logic [5:0] ta4,
                                      input logic [1:0] tt3, input logic [5:0] ta3);
    return {3'b011, 13'd0, tt4, ta4, tt3, ta3};
  endfunction

  function automatic logic [31:0] f_i(input logic [25:0] immhi);
    return {3'b100, 3'd0, immhi};
  endfunction

  function automatic logic [31:0] f_d(input logic [3:0] funct, input logic immab,
                                      input logic [5:0] immlo, input logic [5:0] ta2,
                                      input logic [5:0] ta1, input logic [1:0] tt1);
    return {3'b000, funct, immab, immlo, 4'd0, ta2, tt1, ta1};
  endfunction

  function automatic logic [31:0] f_w(input logic [5:0] immlo, input logic [9:0] offset);
    return {3'b101, 4'd0, 1'b0, immlo, 8'd0, offset};
  endfunction

  // Present one word for exactly one clock edge; results are sampled 1 ns later.
  task automatic send(input logic [31:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready",  in_ready, 1);
    check_eq("rst_err",       err, 0);
    check_eq("rst_prog_done", prog_done, 0);
    check_eq("rst_frag_done", frag_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fragment: T, I, D merged into one bundle
    send(f_hdr(1'b0, 7'd3));
    check_eq("t1_hdr_frag_done", frag_done, 0);
    send(f_t(2'd1, 6'd9, 2'd2, 6'd5));
    check_eq("t1_t_err", err, 0);
    send(f_i(26'd1));
    send(f_d(4'h3, 1'b1, 6'h02, 6'd0, 6'd1, 2'd3));
    check_eq("t1_valid",  out_valid, 1);
    check_eq("t1_imm",    out_imm, 32'h0000_0042);
    check_eq("t1_has_t",  out_has_t, 1);
    check_eq("t1_has_i",  out_has_i, 1);
    check_eq("t1_ta",     out_ta, {6'd9, 6'd5, 6'd0, 6'd1});
    check_eq("t1_tt",     out_tt, {2'd1, 2'd2, 2'd0, 2'd3});
    check_eq("t1_slot",   out_slot, 2);
    check_eq("t1_funct",  out_funct, 4'h3);
    check_eq("t1_immab",  out_immab, 1);
    check_eq("t1_op",     out_op, 3'b000);
    check_eq("t1_offset", out_offset, 0);
    check_eq("t1_frag_done", frag_done, 1);
    check_eq("t1_err",    err, 0);
    idle();
    check_eq("t1_valid_drop", out_valid, 0);
    check_eq("t1_frag_done_pulse", frag_done, 0);

    // Body word outside a fragment
    send(f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0));
    check_eq("t2_err", err, 1);
    check_eq("t2_code", err_code, 1);
    check_eq("t2_no_bundle", out_valid, 0);
    send(f_hdr(1'b0, 7'd1));
    send(f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0));
    check_eq("t2_frag_done", frag_done, 1);
    check_eq("t2_slot", out_slot, 0);

    // Duplicate T that also dangles at the end -> code 3
    send(f_hdr(1'b0, 7'd2));
    send(f_t(2'd0, 6'd1, 2'd0, 6'd2));
    check_eq("t3_first_t_err", err, 0);
    send(f_t(2'd0, 6'd3, 2'd0, 6'd4));
    check_eq("t3_err", err, 1);
    check_eq("t3_code", err_code, 3);
    check_eq("t3_frag_done", frag_done, 1);
    send(f_hdr(1'b0, 7'd1));
    send(f_d(4'h0, 1'b0, 6'h00, 6'd7, 6'd8, 2'd0));
    check_eq("t3_has_t", out_has_t, 0);
    check_eq("t3_ta", out_ta, {6'd0, 6'd0, 6'd7, 6'd8});

    // Duplicate I overwrites -> code 2
    send(f_hdr(1'b0, 7'd3));
    send(f_i(26'd5));
    send(f_i(26'd7));
    check_eq("t4_err", err, 1);
    check_eq("t4_code", err_code, 2);
    send(f_d(4'h0, 1'b0, 6'h03, 6'd0, 6'd0, 2'd0));
    check_eq("t4_imm", out_imm, 32'h0000_01C3);
    check_eq("t4_has_i", out_has_i, 1);
    check_eq("t4_frag_done", frag_done, 1);

    // Reserved opcode counts as a body word, code 0
    send(f_hdr(1'b0, 7'd2));
    send(32'h4000_0000);
    check_eq("t5_err", err, 1);
    check_eq("t5_code", err_code, 0);
    send(f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0));
    check_eq("t5_slot", out_slot, 1);
    check_eq("t5_frag_done", frag_done, 1);

    // Header inside a fragment aborts it
    send(f_hdr(1'b0, 7'd3));
    send(f_t(2'd0, 6'd1, 2'd0, 6'd1));
    send(f_hdr(1'b0, 7'd1));
    check_eq("t6_err", err, 1);
    check_eq("t6_code", err_code, 3);
    check_eq("t6_no_frag_done", frag_done, 0);
    send(f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0));
    check_eq("t6_has_t", out_has_t, 0);
    check_eq("t6_slot", out_slot, 0);
    check_eq("t6_frag_done", frag_done, 1);

    // Backpressure: three D words with out_ready low for 4 cycles
    send(f_hdr(1'b0, 7'd3));
    out_ready = 1'b0;
    in_word   = f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0);
    in_valid  = 1'b1;
    idle();
    check_eq("t7_valid0", out_valid, 1);
    check_eq("t7_in_ready_low", in_ready, 0);
    in_word = f_d(4'h0, 1'b0, 6'h02, 6'd0, 6'd0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check_eq("t7_stall_slot", out_slot, 0);
      check_eq("t7_stall_imm", out_imm, 1);
      check_eq("t7_stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("t7_in_ready_release", in_ready, 1);
    idle();
    check_eq("t7_slot1", out_slot, 1);
    check_eq("t7_imm1", out_imm, 2);
    check_eq("t7_valid1", out_valid, 1);
    in_word = f_d(4'h0, 1'b0, 6'h03, 6'd0, 6'd0, 2'd0);
    idle();
    in_valid = 1'b0;
    check_eq("t7_slot2", out_slot, 2);
    check_eq("t7_imm2", out_imm, 3);
    check_eq("t7_frag_done", frag_done, 1);
    idle();
    check_eq("t7_drain", out_valid, 0);

    // End-of-program fragment with a sign-extended W immediate
    send(f_hdr(1'b1, 7'd1));
    send(f_w(6'h3F, 10'h3FF));
    check_eq("t8_imm", out_imm, 32'hFFFF_FFFF);
    check_eq("t8_offset", out_offset, 10'h3FF);
    check_eq("t8_op", out_op, 3'b101);
    check_eq("t8_ta", out_ta, 0);
    check_eq("t8_prog_done", prog_done, 1);
    check_eq("t8_frag_done", frag_done, 1);
    idle();
    check_eq("t8_prog_done_held", prog_done, 1);
    send(f_hdr(1'b0, 7'd2));
    check_eq("t8_prog_done_clr", prog_done, 0);

    // Asynchronous reset mid-fragment with a bundle held
    out_ready = 1'b0;
    send(f_d(4'h5, 1'b1, 6'h09, 6'd0, 6'd3, 2'd1));
    check_eq("t9_valid_before", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t9_valid", out_valid, 0);
    check_eq("t9_imm", out_imm, 0);
    check_eq("t9_funct", out_funct, 0);
    check_eq("t9_ta", out_ta, 0);
    check_eq("t9_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(f_d(4'h0, 1'b0, 6'h01, 6'd0, 6'd0, 2'd0));
    check_eq("t9_err", err, 1);
    check_eq("t9_code", err_code, 1);
    check_eq("t9_no_bundle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
